// File: rtl/radio_frame_serializer.sv
// Packs per-radio I/Q samples into words, buffers them in a small FIFO and shifts them out
// MSB-first with a SYNC marker. Define RADIO_SER_PARITY_EN to append an even-parity bit.
module radio_frame_serializer #(
  parameter int unsigned NUM_RADIOS      = 2,
  parameter int unsigned BITS_PER_SAMPLE = 2,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                  sys_clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_RADIOS*BITS_PER_SAMPLE-1:0] radio_i_i,
  input  logic [NUM_RADIOS*BITS_PER_SAMPLE-1:0] radio_q_i,
  input  logic                                  sample_valid_i,
  input  logic                                  clear_ovf_i,
  output logic                                  data_out_o,
  output logic                                  sync_o,
  output logic                                  overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]           fill_o
);

  localparam int unsigned B  = BITS_PER_SAMPLE;
  localparam int unsigned W  = NUM_RADIOS * 2 * B;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = AW + 1;
`ifdef RADIO_SER_PARITY_EN
  localparam int unsigned FrameLen = W + 1;
`else
  localparam int unsigned FrameLen = W;
`endif
  localparam int unsigned CW = $clog2(FrameLen);
  localparam logic [CW-1:0] CntLast  = CW'(FrameLen - 1);
  localparam logic [AW:0]   FillFull = FW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shift_q, shift_d;
  logic            data_q, data_d;
  logic            sync_q, sync_d;
  logic            ovf_q, ovf_d;
  logic [AW:0]     fill_q, fill_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]    mem_q [FIFO_DEPTH];
  logic [W-1:0]    word_in;
  logic [W-1:0]    head;
  logic            empty, full, push, pop;
`ifdef RADIO_SER_PARITY_EN
  logic            par_q, par_d;
`endif

  // Radio 0 lands in the MSBs: {I0, Q0, I1, Q1, ...}.
  for (genvar r = 0; r < NUM_RADIOS; r++) begin : g_pack
    assign word_in[W-1-2*B*r -: B]   = radio_i_i[r*B +: B];
    assign word_in[W-1-2*B*r-B -: B] = radio_q_i[r*B +: B];
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (fill_q == '0);
  assign full  = (fill_q == FillFull);
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign push  = sample_valid_i && (!full || pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    sync_d  = sync_q;
    pop     = 1'b0;
`ifdef RADIO_SER_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        data_d = 1'b0;
        sync_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        sync_d  = (cnt_q == '0);
        data_d  = shift_q[W-1];
`ifdef RADIO_SER_PARITY_EN
        if (cnt_q == CntLast) data_d = par_q;
`endif
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          if (!empty) pop = 1'b1;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      shift_d = head;
      cnt_d   = '0;
`ifdef RADIO_SER_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (!push && pop) fill_d = fill_q - 1'b1;
    ovf_d = ovf_q;
    if (clear_ovf_i) ovf_d = 1'b0;
    if (sample_valid_i && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= 1'b0;
      sync_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef RADIO_SER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      sync_q   <= sync_d;
      ovf_q    <= ovf_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef RADIO_SER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= word_in;
  end

  assign data_out_o = data_q;
  assign sync_o     = sync_q;
  assign overflow_o = ovf_q;
  assign fill_o     = fill_q;

endmodule

// File: tb/tb_radio_frame_serializer.sv
// Directed self-checking bench for radio_frame_serializer (default 2 radios, 2-bit samples,
// 4-deep FIFO); the parity case runs only when RADIO_SER_PARITY_EN is defined.
module tb_radio_frame_serializer;

`ifdef RADIO_SER_PARITY_EN
  localparam int unsigned FL = 9;
`else
  localparam int unsigned FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ri = '0;
  logic [3:0] rq = '0;
  logic       valid = 1'b0;
  logic       clr = 1'b0;
  logic       dout, sync, ovf;
  logic [2:0] fill;

  int tests = 0;
  int fails = 0;

  // Frame monitor: assembles serial frames starting at each SYNC.
  logic [7:0] got_q[$];
  logic       got_par_q[$];
  logic [7:0] cur;
  int         nb = 0;

  always #5 clk = ~clk;

  radio_frame_serializer #(
    .NUM_RADIOS     (2),
    .BITS_PER_SAMPLE(2),
    .FIFO_DEPTH     (4)
  ) dut (
    .sys_clk_i     (clk),
    .rst_i         (rst),
    .radio_i_i     (ri),
    .radio_q_i     (rq),
    .sample_valid_i(valid),
    .clear_ovf_i   (clr),
    .data_out_o    (dout),
    .sync_o        (sync),
    .overflow_o    (ovf),
    .fill_o        (fill)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k * 29 + 7);
  endfunction

  // word = {I0,Q0,I1,Q1}; ports carry radio r at [2r +: 2]
  task automatic set_word(input logic [7:0] w);
    ri = {w[3:2], w[7:6]};
    rq = {w[1:0], w[5:4]};
  endtask

  // One clock edge with the given strobes; outputs are valid on return (1 ns after the edge).
  task automatic step(input logic v, input logic c);
    valid = v;
    clr   = c;
    @(posedge clk);
    #1;
    valid = 1'b0;
    clr   = 1'b0;
    if (sync) begin
      cur = {7'b0, dout};
      nb  = 1;
    end else if (nb > 0) begin
      if (nb < 8) cur = {cur[6:0], dout};
      else        got_par_q.push_back(dout);
      nb++;
    end
    if (nb == FL) begin
      got_q.push_back(cur);
      nb = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] e2;
    logic [7:0] wk;
    logic       ed, es;
    int         m, k, b, highs, nexp;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_data", dout, 0);
    check("rst_sync", sync, 0);
    check("rst_ovf", ovf, 0);
    check("rst_fill", fill, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single word: packing, two-cycle latency, SYNC on first bit only, then idle
    e2 = 8'b01_00_10_11;
    ri = 4'b10_01;
    rq = 4'b11_00;
    step(1'b1, 1'b0);
    check("t2_fill_wr", fill, 1);
    step(1'b0, 1'b0);
    check("t2_fill_pop", fill, 0);
    check("t2_no_bit_yet", dout, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("t2_bit%0d", i), dout, e2[7-i]);
      check($sformatf("t2_sync%0d", i), sync, (i == 0) ? 1 : 0);
    end
`ifdef RADIO_SER_PARITY_EN
    step(1'b0, 1'b0);
    check("t2_parity", dout, 0);
    check("t2_parity_sync", sync, 0);
`endif
    step(1'b0, 1'b0);
    check("t2_idle_data", dout, 0);
    check("t2_idle_sync", sync, 0);
    idle(4);

    // Strobe once per frame for 32 words: seamless stream, FIFO never above 1
    for (int c = 0; c < 32 * FL + 4; c++) begin
      logic v;
      v = (c % FL == 0) && (c / FL < 32);
      if (v) set_word(pat(c / FL));
      step(v, 1'b0);
      m  = c - 2;
      ed = 1'b0;
      es = 1'b0;
      if (m >= 0 && m / int'(FL) < 32) begin
        k  = m / FL;
        b  = m % FL;
        wk = pat(k);
        ed = (b < 8) ? wk[7-b] : ^wk;
        es = (b == 0);
      end
      check($sformatf("t3_data_c%0d", c), dout, ed);
      check($sformatf("t3_sync_c%0d", c), sync, es);
      check($sformatf("t3_fill_le1_c%0d", c), fill <= 3'd1, 1);
    end
    check("t3_no_ovf", ovf, 0);
    idle(4);

    // Strobe every cycle for 10 cycles: FIFO saturates, overflow is sticky until cleared.
    // With 8-bit frames the 10th strobe lands on the first frame-end pop and is accepted.
    got_q.delete();
    got_par_q.delete();
    for (int c = 0; c < 10; c++) begin
      set_word(pat(100 + c));
      step(1'b1, 1'b0);
      if (c == 4) check("t4_fill_full", fill, 4);
      if (c == 4) check("t4_ovf_before", ovf, 0);
      if (c == 5) check("t4_ovf_set", ovf, 1);
      check($sformatf("t4_fill_le4_c%0d", c), fill <= 3'd4, 1);
    end
    idle(6 * FL + 4);
    nexp = (FL == 8) ? 6 : 5;
    check("t4_nwords", got_q.size(), nexp);
    for (int i = 0; i < 5; i++)
      if (got_q.size() > i) check($sformatf("t4_word%0d", i), got_q[i], pat(100 + i));
    if (nexp == 6 && got_q.size() > 5) check("t4_word5", got_q[5], pat(109));
    check("t4_ovf_sticky", ovf, 1);
    check("t4_drained", fill, 0);
    step(1'b0, 1'b1);
    check("t4_ovf_cleared", ovf, 0);
    idle(2);

    // Full FIFO with a strobe exactly on the pop edge: accepted, FILL stays 4, no overflow
    got_q.delete();
    got_par_q.delete();
    for (int c = 0; c <= FL + 1; c++) begin
      logic v;
      v = (c <= 4) || (c == FL + 1);
      set_word(pat(200 + c));
      step(v, 1'b0);
      if (c == FL) check("t5_full_before_pop", fill, 4);
    end
    check("t5_fill_kept", fill, 4);
    check("t5_no_ovf", ovf, 0);
    idle(6 * FL + 4);
    check("t5_nwords", got_q.size(), 6);
    if (got_q.size() > 0) check("t5_first", got_q[0], pat(200));
    if (got_q.size() > 5) check("t5_last", got_q[5], pat(200 + FL + 1));

    // Async reset mid-frame; overflow set with a coincident clear (set wins)
    got_q.delete();
    got_par_q.delete();
    for (int c = 0; c < 6; c++) begin
      set_word(pat(300 + c));
      step(1'b1, c == 5);
    end
    check("t1_set_wins", ovf, 1);
    idle(3);
    check("t1_fill_pre", fill, 4);
    #2 rst = 1'b1;
    #1;
    check("t1_data", dout, 0);
    check("t1_sync", sync, 0);
    check("t1_ovf", ovf, 0);
    check("t1_fill", fill, 0);
    @(negedge clk);
    rst = 1'b0;
    nb  = 0;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0);
      if (dout || sync) highs++;
    end
    check("t1_quiet_after_rst", highs, 0);
    check("t1_fill_after", fill, 0);

`ifdef RADIO_SER_PARITY_EN
    // Parity frames: 8'hB4 has even weight, 8'hB5 odd
    got_q.delete();
    got_par_q.delete();
    set_word(8'hB4);
    step(1'b1, 1'b0);
    idle(12);
    set_word(8'hB5);
    step(1'b1, 1'b0);
    idle(12);
    check("t6_nwords", got_q.size(), 2);
    if (got_q.size() > 1 && got_par_q.size() > 1) begin
      check("t6_w0", got_q[0], 8'hB4);
      check("t6_p0", got_par_q[0], 0);
      check("t6_w1", got_q[1], 8'hB5);
      check("t6_p1", got_par_q[1], 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
